// File: rtl/serializador_param.sv
// ----------------------------------------------------------------------------
// serializador_param
//   Parallel-to-serial converter. A word on d is captured when load is high
//   in IDLE, then shifted out one bit per accepted transfer, LSB first
//   (MSB_FIRST=0) or MSB first (MSB_FIRST=1). A one-cycle done pulse in FIN
//   marks the end of each word.
//
// Handshake (both sides use strict valid/ready):
//   producer side: a word moves when load=1 and load_ready=1 on a rising edge.
//   consumer side: a bit moves when sout_valid=1 and sout_ready=1 on a rising
//   edge; while sout_valid=1 and sout_ready=0, sout and all state are held.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   d[N-1:0]    parallel word
//   load        word-valid strobe
//   load_ready  block can accept a word this cycle
//   sout        current serial bit
//   sout_valid  sout holds a valid bit
//   sout_ready  consumer accepts sout this cycle
//   busy        word in flight (SHIFT or FIN)
//   done        one-cycle pulse after the last bit is accepted
//   state_dbg   current FSM state (IDLE=0, SHIFT=1, FIN=2)
// ----------------------------------------------------------------------------
module serializador_param #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         load,
    output logic         load_ready,
    output logic         sout,
    output logic         sout_valid,
    input  logic         sout_ready,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_dbg
);

    localparam int CW      = (N > 1) ? $clog2(N) : 1;
    localparam int OUT_IDX = MSB_FIRST ? N - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    shreg;
    logic [N-1:0]    shreg_shift;
    logic [N-1:0]    shreg_nxt;
    logic [CW-1:0]   cnt;
    logic            take;
    logic            xfer;
    logic            last;
    logic            shreg_en;

    assign take     = (state == IDLE) && load;
    assign xfer     = (state == SHIFT) && sout_ready;
    assign last     = (cnt == CW'(N - 1));
    assign shreg_en = take || xfer;

    // Reset gates load_ready so every output reads 0 while rst is low and
    // load_ready rises as soon as rst is released.
    assign load_ready = rst && (state == IDLE);
    assign state_dbg  = state;

    // Shift toward the output end, filling the vacated bit with 0.
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            if (MSB_FIRST == 1'b0) begin : g_lsb
                if (i == N - 1) begin : g_top
                    assign shreg_shift[i] = 1'b0;
                end else begin : g_mid
                    assign shreg_shift[i] = shreg[i + 1];
                end
            end else begin : g_msb
                if (i == 0) begin : g_bot
                    assign shreg_shift[i] = 1'b0;
                end else begin : g_mid
                    assign shreg_shift[i] = shreg[i - 1];
                end
            end

            assign shreg_nxt[i] = take ? d[i] : shreg_shift[i];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shreg[i] <= 1'b0;
                end else if (shreg_en) begin
                    shreg[i] <= shreg_nxt[i];
                end
            end
        end
    endgenerate

    // sout is a register that tracks the output end of the shift register
    // while in SHIFT. The final transfer does not update it, so outside SHIFT
    // it keeps the last bit that was presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        sout       <= d[OUT_IDX];
                        sout_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sout_ready) begin
                        if (last) begin
                            state      <= FIN;
                            sout_valid <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            cnt  <= cnt + CW'(1);
                            sout <= shreg_shift[OUT_IDX];
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    sout_valid <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
